// File: rtl/adc_align_ctrl_pkg.sv
// Shared definitions for the ADC receiver alignment sequencer: state codes and
// the default deserialised frame pattern used by the receiver.
package adc_align_ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_CAL     = 4'd1;
  localparam logic [3:0] S_CAL_WT  = 4'd2;
  localparam logic [3:0] S_DRST    = 4'd3;
  localparam logic [3:0] S_DRST_WT = 4'd4;
  localparam logic [3:0] S_ALIGN   = 4'd5;
  localparam logic [3:0] S_SLIP_WT = 4'd6;
  localparam logic [3:0] S_VERIFY  = 4'd7;
  localparam logic [3:0] S_LOCKED  = 4'd8;
  localparam logic [3:0] S_FAIL    = 4'd9;

  localparam logic [5:0] FRAME_DEFAULT = 6'b111000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/adc_align_ctrl_frame_chk.sv
// Frame word comparator with consecutive good/bad frame counters; the
// sequencer decides when each counter runs, holds or clears.
module adc_align_ctrl_frame_chk
  import adc_align_ctrl_pkg::*;
#(
  parameter logic [5:0] FRAME    = FRAME_DEFAULT,
  parameter int         GOOD_MAX = 256,
  parameter int         BAD_MAX  = 4,
  parameter int         GOOD_W   = 9,
  parameter int         BAD_W    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        fr_r,
  input  logic              good_en,
  input  logic              bad_en,
  input  logic              bad_clr,
  output logic              match,
  output logic [GOOD_W-1:0] good_cnt,
  output logic [BAD_W-1:0]  bad_cnt
);

  assign match = (fr_r == FRAME);

  // Both counters saturate at their limits so they can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      if (!good_en || !match)
        good_cnt <= '0;
      else if (good_cnt != GOOD_W'(GOOD_MAX))
        good_cnt <= good_cnt + 1'b1;

      if (bad_clr || (bad_en && match))
        bad_cnt <= '0;
      else if (bad_en && (bad_cnt != BAD_W'(BAD_MAX)))
        bad_cnt <= bad_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_align_ctrl.sv
// ADC receiver sequencer: IODELAY calibrate/reset, bitslip frame alignment,
// lock verification and loss monitoring. ADC_RECAL_EN adds periodic recalibration.
module adc_align_ctrl
  import adc_align_ctrl_pkg::*;
#(
  parameter logic [5:0] FRAME        = FRAME_DEFAULT,
  parameter int         CAL_WAIT     = 64,
  parameter int         SLIP_WAIT    = 16,
  parameter int         MAX_SLIPS    = 12,
  parameter int         VERIFY_LEN   = 256,
  parameter int         LOSS_THR     = 4,
  parameter int         RECAL_PERIOD = 2**20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  fr_r,
  output logic        del_cal,
  output logic        del_rst,
  output logic        bs,
  output logic        locked,
  output logic        failed,
  output logic        loss,
  output logic [15:0] errcnt,
  output logic [3:0]  state
);

  localparam int WAIT_W = $clog2(max_int(CAL_WAIT, SLIP_WAIT) + 1);
  localparam int SLIP_W = $clog2(MAX_SLIPS + 1);
  localparam int GOOD_W = $clog2(VERIFY_LEN + 1);
  localparam int BAD_W  = $clog2(LOSS_THR + 1);

  state_t            state_reg, state_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic [SLIP_W-1:0] slip_reg, slip_next;
  logic [15:0]       errcnt_next;
  logic              bs_next;
  logic              recal_pulse;
  logic              check_en;
  logic              match;
  logic [GOOD_W-1:0] good_cnt;
  logic [BAD_W-1:0]  bad_cnt;

  adc_align_ctrl_frame_chk #(
    .FRAME    (FRAME),
    .GOOD_MAX (VERIFY_LEN),
    .BAD_MAX  (LOSS_THR),
    .GOOD_W   (GOOD_W),
    .BAD_W    (BAD_W)
  ) u_frame_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .fr_r     (fr_r),
    .good_en  ((state_reg == S_ALIGN) || (state_reg == S_VERIFY)),
    .bad_en   ((state_reg == S_LOCKED) && check_en),
    .bad_clr  (state_reg != S_LOCKED),
    .match    (match),
    .good_cnt (good_cnt),
    .bad_cnt  (bad_cnt)
  );

`ifdef ADC_RECAL_EN
  localparam int RECAL_W = $clog2(RECAL_PERIOD);
  localparam int SUPP_W  = $clog2(CAL_WAIT + 2);

  logic [RECAL_W-1:0] recal_reg;
  logic [SUPP_W-1:0]  supp_reg;

  // Suppression window covers the pulse cycle plus CAL_WAIT cycles after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      recal_reg <= '0;
      supp_reg  <= '0;
    end else if (state_reg != S_LOCKED) begin
      recal_reg <= '0;
      supp_reg  <= '0;
    end else if (recal_pulse) begin
      recal_reg <= '0;
      supp_reg  <= SUPP_W'(CAL_WAIT + 1);
    end else begin
      recal_reg <= recal_reg + 1'b1;
      if (supp_reg != '0)
        supp_reg <= supp_reg - 1'b1;
    end
  end

  assign recal_pulse = (state_reg == S_LOCKED) && (recal_reg == RECAL_W'(RECAL_PERIOD - 1));
  assign check_en    = (supp_reg == '0);
`else
  logic unused_recal;
  assign unused_recal = (RECAL_PERIOD != 0);
  assign recal_pulse  = 1'b0;
  assign check_en     = 1'b1;
`endif

  always_comb begin
    state_next  = state_reg;
    wait_next   = '0;
    slip_next   = slip_reg;
    errcnt_next = errcnt;
    bs_next     = 1'b0;
    if (!start) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          state_next  = S_CAL;
          errcnt_next = '0;
        end
        S_CAL:
          state_next = S_CAL_WT;
        S_CAL_WT:
          if (wait_reg == WAIT_W'(CAL_WAIT - 1)) state_next = S_DRST;
          else                                   wait_next  = wait_reg + 1'b1;
        S_DRST: begin
          state_next = S_DRST_WT;
          slip_next  = '0;
        end
        S_DRST_WT:
          if (wait_reg == WAIT_W'(CAL_WAIT - 1)) begin
            state_next = S_ALIGN;
            slip_next  = '0;
          end else begin
            wait_next = wait_reg + 1'b1;
          end
        S_ALIGN:
          if (match) begin
            state_next = S_VERIFY;
          end else if (slip_reg == SLIP_W'(MAX_SLIPS)) begin
            state_next = S_FAIL;
          end else begin
            state_next = S_SLIP_WT;
            slip_next  = slip_reg + 1'b1;
            bs_next    = 1'b1;
          end
        S_SLIP_WT:
          if (wait_reg == WAIT_W'(SLIP_WAIT - 1)) state_next = S_ALIGN;
          else                                    wait_next  = wait_reg + 1'b1;
        // good_cnt already includes the matching frame seen in ALIGN.
        S_VERIFY:
          if (!match)                                   state_next = S_ALIGN;
          else if (good_cnt == GOOD_W'(VERIFY_LEN - 1)) state_next = S_LOCKED;
        S_LOCKED:
          if (check_en && !match) begin
            if (errcnt != 16'hFFFF)
              errcnt_next = errcnt + 16'd1;
            if (bad_cnt == BAD_W'(LOSS_THR - 1)) begin
              state_next = S_ALIGN;
              slip_next  = '0;
            end
          end
        S_FAIL: ;
        default:
          state_next = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      wait_reg  <= '0;
      slip_reg  <= '0;
      errcnt    <= '0;
      del_cal   <= 1'b0;
      del_rst   <= 1'b0;
      bs        <= 1'b0;
      locked    <= 1'b0;
      failed    <= 1'b0;
      loss      <= 1'b0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      slip_reg  <= slip_next;
      errcnt    <= errcnt_next;
      del_cal   <= (state_next == S_CAL) || (recal_pulse && (state_next == S_LOCKED));
      del_rst   <= (state_next == S_DRST);
      bs        <= bs_next;
      locked    <= (state_next == S_LOCKED);
      failed    <= (state_next == S_FAIL);
      loss      <= (state_reg == S_LOCKED) && (state_next == S_ALIGN);
    end
  end

  assign state = state_reg;

endmodule

// File: tb/tb_adc_align_ctrl.sv
// Self-checking bench for adc_align_ctrl: table of alignment scenarios with a
// scoreboard queue, plus hand-written loss, abort and reset sequences.
module tb_adc_align_ctrl;

  localparam logic [5:0] FRAME      = 6'b111000;
  localparam int         CAL_WAIT   = 64;
  localparam int         SLIP_WAIT  = 16;
  localparam int         VERIFY_LEN = 256;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_CAL_WT  = 4'd2;
  localparam logic [3:0] ST_ALIGN   = 4'd5;
  localparam logic [3:0] ST_SLIP_WT = 4'd6;
  localparam logic [3:0] ST_VERIFY  = 4'd7;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  fr_r;
  logic        del_cal, del_rst, bs, locked, failed, loss;
  logic [15:0] errcnt;
  logic [3:0]  state;

  adc_align_ctrl #(.RECAL_PERIOD(1000)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .fr_r    (fr_r),
    .del_cal (del_cal),
    .del_rst (del_rst),
    .bs      (bs),
    .locked  (locked),
    .failed  (failed),
    .loss    (loss),
    .errcnt  (errcnt),
    .state   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int rot;
    bit never;
    int exp_bs;
    bit exp_locked;
    bit exp_failed;
  } vec_t;

  typedef struct {
    int bs;
    bit locked;
    bit failed;
    int lock_off;
  } exp_t;

  vec_t vecs[5];
  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  // Receiver model and per-run observations
  int rot;
  bit never;
  bit bad;
  int cyc, cal_at, rst_at, lock_at, bs_cnt, last_bs, min_gap, overlap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [5:0] rotl(input logic [5:0] v, input int n);
    logic [5:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[4:0], r[5]};
    return r;
  endfunction

  task automatic drive_frame();
    if (bad)        fr_r = 6'b000000;
    else if (never) fr_r = 6'b101010;
    else            fr_r = rotl(FRAME, rot);
  endtask

  // One clock: sample at the falling edge, then let the receiver react to BS.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (del_cal && cal_at < 0) cal_at = cyc;
    if (del_rst && rst_at < 0) rst_at = cyc;
    if (locked && lock_at < 0) lock_at = cyc;
    if (int'(del_cal) + int'(del_rst) + int'(bs) > 1) overlap++;
    if (bs) begin
      if (bs_cnt > 0 && (cyc - last_bs) < min_gap) min_gap = cyc - last_bs;
      last_bs = cyc;
      bs_cnt++;
      rot = (rot + 5) % 6;
    end
    drive_frame();
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    exp_t e;
    v = vecs[idx];
    start = 1'b0;
    step();
    step();
    check("idle_state", state, ST_IDLE);
    check("idle_flags", {locked, failed}, 0);
    rot = v.rot; never = v.never; bad = 1'b0;
    drive_frame();
    sb_q.push_back('{bs: v.exp_bs, locked: v.exp_locked, failed: v.exp_failed,
                     lock_off: 2*CAL_WAIT + VERIFY_LEN + 2 + v.exp_bs*(SLIP_WAIT + 1)});
    cyc = 0; cal_at = -1; rst_at = -1; lock_at = -1;
    bs_cnt = 0; last_bs = 0; min_gap = 1000000; overlap = 0;
    start = 1'b1;
    while (!(locked || failed) && cyc < 6000) step();
    e = sb_q.pop_front();
    check("run_done_in_time", cyc < 6000, 1);
    check("run_bs_count", bs_cnt, e.bs);
    check("run_locked", locked, e.locked);
    check("run_failed", failed, e.failed);
    check("run_errcnt", errcnt, 0);
    check("del_cal_latency", cal_at, 1);
    check("del_rst_after_cal", rst_at - cal_at, CAL_WAIT + 1);
    check("pulse_overlap", overlap, 0);
    if (e.locked) check("lock_latency", lock_at - cal_at, e.lock_off);
    if (e.bs >= 2) check("bs_spacing_ok", min_gap >= SLIP_WAIT + 1, 1);
    if (e.failed) begin
      repeat (40) step();
      check("no_extra_bs", bs_cnt, e.bs);
      check("failed_held", failed, 1);
    end
    $display("run %0d: rot=%0d never=%0d bs=%0d locked=%0d failed=%0d cycles=%0d",
             idx, v.rot, v.never, bs_cnt, locked, failed, cyc);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{rot: 0, never: 0, exp_bs: 0,  exp_locked: 1, exp_failed: 0};
    vecs[1] = '{rot: 3, never: 0, exp_bs: 3,  exp_locked: 1, exp_failed: 0};
    vecs[2] = '{rot: 5, never: 0, exp_bs: 5,  exp_locked: 1, exp_failed: 0};
    vecs[3] = '{rot: 0, never: 1, exp_bs: 12, exp_locked: 0, exp_failed: 1};
    vecs[4] = '{rot: 1, never: 0, exp_bs: 1,  exp_locked: 1, exp_failed: 0};

    rst_n = 1'b0; start = 1'b0; rot = 0; never = 1'b0; bad = 1'b0;
    drive_frame();
    repeat (3) @(negedge clk);
    check("reset_outputs", {del_cal, del_rst, bs, locked, failed, loss, errcnt, state}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(i);

    // Bad frames while locked: three are tolerated, four declare loss.
    bad = 1'b1; drive_frame();
    repeat (3) step();
    bad = 1'b0; drive_frame();
    repeat (2) step();
    check("errcnt_after_3_bad", errcnt, 3);
    check("locked_after_3_bad", locked, 1);
    check("no_loss_after_3_bad", loss, 0);
    bad = 1'b1; drive_frame();
    repeat (3) step();
    check("no_loss_before_4th", loss, 0);
    step();
    check("loss_pulse", loss, 1);
    check("locked_dropped", locked, 0);
    check("state_align_on_loss", state, ST_ALIGN);
    check("errcnt_after_7_bad", errcnt, 7);
    bad = 1'b0; drive_frame();
    step();
    check("loss_one_cycle", loss, 0);
    $display("loss sequence: errcnt=%0d state=%0d", errcnt, state);

    // Abort during SLIP_WT
    start = 1'b0; step();
    rot = 3; never = 1'b0; drive_frame();
    start = 1'b1;
    for (int i = 0; i < 500 && state != ST_SLIP_WT; i++) step();
    check("reach_slip_wt", state, ST_SLIP_WT);
    start = 1'b0; step();
    check("abort_slip_state", state, ST_IDLE);
    check("abort_slip_bs", bs, 0);

    // Abort during VERIFY
    rot = 0; drive_frame();
    start = 1'b1;
    for (int i = 0; i < 500 && state != ST_VERIFY; i++) step();
    check("reach_verify", state, ST_VERIFY);
    repeat (5) step();
    start = 1'b0; step();
    check("abort_verify_state", state, ST_IDLE);
    check("abort_verify_locked", locked, 0);
    $display("abort sequence: state=%0d", state);

    // Asynchronous reset in the middle of CAL_WT
    start = 1'b1;
    for (int i = 0; i < 100 && state != ST_CAL_WT; i++) step();
    repeat (10) step();
    check("reach_cal_wt", state, ST_CAL_WT);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {del_cal, del_rst, bs, locked, failed, loss, errcnt, state}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("async reset: state=%0d", state);

`ifdef ADC_RECAL_EN
    begin
      int t1, t2, drops;
      run_vec(0);
      t1 = -1; t2 = -1; drops = 0;
      for (int i = 0; i < 1500 && t1 < 0; i++) begin
        step();
        if (del_cal) t1 = cyc;
        if (!locked) drops++;
      end
      for (int i = 0; i < 1500 && t2 < 0; i++) begin
        step();
        if (del_cal) t2 = cyc;
        if (!locked) drops++;
      end
      check("recal_period", t2 - t1, 1000);
      bad = 1'b1; drive_frame();
      repeat (10) step();
      bad = 1'b0; drive_frame();
      repeat (5) step();
      check("recal_suppressed_errcnt", errcnt, 0);
      check("recal_locked_held", locked, 1);
      check("recal_no_drop", drops, 0);
      $display("recal: interval=%0d errcnt=%0d", t2 - t1, errcnt);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
